// File: rtl/iob_axistream_out_rdctrl.sv
// Read-side sequencer for the 9-bit AXI-stream output FIFO.
// Drains FIFO entries {tdata[7:0], tlast} at up to one byte per cycle and
// packs them into DATA_W-wide words, lane 0 first. A word is closed by
// tlast, by filling every lane, or by an explicit flush of a partial word.
// The word is then offered on a valid/ready handshake, and a frame counter
// counts accepted words that carry tlast.
module iob_axistream_out_rdctrl #(
   parameter int DATA_W      = 32,
   parameter int NB_W        = $clog2(DATA_W / 8) + 1,
   parameter int FRAME_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   arst,
   input  logic                   en,
   input  logic                   clr,
   input  logic                   flush,
   output logic                   fifo_r_en,
   input  logic [8:0]             fifo_r_data,
   input  logic                   fifo_empty,
   output logic                   word_valid,
   input  logic                   word_ready,
   output logic [DATA_W-1:0]      word_data,
   output logic [NB_W-1:0]        word_nbytes,
   output logic                   word_last,
   output logic [FRAME_CNT_W-1:0] frame_cnt
);

   localparam int NBYTES = DATA_W / 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,  // no read outstanding, may hold a partial word
      ST_WAIT  = 2'd1,  // FIFO data for last cycle's read is on fifo_r_data
      ST_VALID = 2'd2   // closed word offered to the consumer
   } state_t;

   state_t          state;
   logic [NB_W-1:0] byte_cnt;
   logic [NB_W-1:0] byte_cnt_inc;
   logic            word_close;
   logic            can_read;

   // Byte count doubles as the number of valid lanes in the offered word.
   assign word_nbytes = byte_cnt;

   // Read strobe: decided from state and live inputs so back-to-back reads
   // reach one byte per cycle; clr blocks any read in its cycle.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      byte_cnt_inc = byte_cnt + NB_W'(1);
      word_close   = fifo_r_data[0] | (byte_cnt_inc == NB_W'(NBYTES));
      can_read     = en & ~fifo_empty & ~clr;
      fifo_r_en    = 1'b0;
      case (state)
         ST_IDLE: fifo_r_en = can_read;
         ST_WAIT: fifo_r_en = can_read & ~word_close;
         default: fifo_r_en = 1'b0;
      endcase
   end

   // Sequencer FSM with registered word outputs and frame counter.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state      <= ST_IDLE;
         byte_cnt   <= '0;
         word_valid <= 1'b0;
         word_data  <= '0;
         word_last  <= 1'b0;
         frame_cnt  <= '0;
      end else if (clr) begin
         // A byte arriving in WAIT this cycle was already popped and is dropped.
         state      <= ST_IDLE;
         byte_cnt   <= '0;
         word_valid <= 1'b0;
         word_data  <= '0;
         word_last  <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (fifo_r_en) begin
                  state <= ST_WAIT;
               end else if (flush && (byte_cnt != '0)) begin
                  state      <= ST_VALID;
                  word_valid <= 1'b1;
               end
            end

            ST_WAIT: begin
               // Flush is ignored here; the in-flight byte always lands.
               for (int i = 0; i < NBYTES; i++) begin
                  if (byte_cnt == NB_W'(i)) begin
                     word_data[i*8 +: 8] <= fifo_r_data[8:1];
                  end
               end
               byte_cnt <= byte_cnt_inc;
               if (fifo_r_data[0]) begin
                  word_last <= 1'b1;
               end
               if (word_close) begin
                  state      <= ST_VALID;
                  word_valid <= 1'b1;
               end else if (!fifo_r_en) begin
                  state <= ST_IDLE;
               end
            end

            ST_VALID: begin
               // Clearing on accept keeps unused lanes of the next word at zero.
               if (word_ready) begin
                  if (word_last) begin
                     frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
                  end
                  state      <= ST_IDLE;
                  byte_cnt   <= '0;
                  word_valid <= 1'b0;
                  word_data  <= '0;
                  word_last  <= 1'b0;
               end
            end

            default: begin
               state      <= ST_IDLE;
               byte_cnt   <= '0;
               word_valid <= 1'b0;
               word_data  <= '0;
               word_last  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iob_axistream_out_rdctrl.sv
// Directed bench for iob_axistream_out_rdctrl with DATA_W=32.
// A behavioural FIFO feeds the DUT; inputs change on the falling edge and
// outputs are sampled on or just after the falling edge.
module tb_iob_axistream_out_rdctrl;

   localparam int DATA_W      = 32;
   localparam int NB_W        = 3;
   localparam int FRAME_CNT_W = 16;

   logic                   clk = 1'b0;
   logic                   arst;
   logic                   en;
   logic                   clr;
   logic                   flush;
   logic                   fifo_r_en;
   logic [8:0]             fifo_r_data = '0;
   logic                   fifo_empty;
   logic                   word_valid;
   logic                   word_ready;
   logic [DATA_W-1:0]      word_data;
   logic [NB_W-1:0]        word_nbytes;
   logic                   word_last;
   logic [FRAME_CNT_W-1:0] frame_cnt;

   int total = 0;
   int bad   = 0;

   iob_axistream_out_rdctrl #(
      .DATA_W(DATA_W),
      .FRAME_CNT_W(FRAME_CNT_W)
   ) dut (
      .clk(clk),
      .arst(arst),
      .en(en),
      .clr(clr),
      .flush(flush),
      .fifo_r_en(fifo_r_en),
      .fifo_r_data(fifo_r_data),
      .fifo_empty(fifo_empty),
      .word_valid(word_valid),
      .word_ready(word_ready),
      .word_data(word_data),
      .word_nbytes(word_nbytes),
      .word_last(word_last),
      .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural FIFO: data appears one cycle after the read strobe.
   logic [8:0] mem [0:63];
   int wr_ptr = 0;
   int rd_ptr = 0;

   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (fifo_r_en) begin
         fifo_r_data <= mem[rd_ptr % 64];
         rd_ptr      <= rd_ptr + 1;
      end
   end

   task automatic push(input logic [7:0] b, input logic l);
      mem[wr_ptr % 64] = {b, l};
      wr_ptr++;
   endtask

   task automatic wait_valid(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (word_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      if ({fifo_r_en, word_valid, word_last} !== 3'b000) begin
         bad++; $display("FAIL reset_ctrl: got %b want 000", {fifo_r_en, word_valid, word_last});
      end
      total++;
      if ({word_data, word_nbytes, frame_cnt} !== '0) begin
         bad++; $display("FAIL reset_regs: got data=%h nb=%0d fc=%0d want all 0", word_data, word_nbytes, frame_cnt);
      end
      total++;
      arst = 1'b0;
   endtask

   task automatic test_full_word();
      int ones = 0;
      @(negedge clk);
      push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b0); push(8'h44, 1'b0);
      en = 1'b1;
      word_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         if (fifo_r_en === 1'b1) ones++;
      end
      @(negedge clk); #1;
      if (ones !== 4 || fifo_r_en !== 1'b0) begin
         bad++; $display("FAIL full_rd_run: got ones=%0d then %b want 4 then 0", ones, fifo_r_en);
      end
      total++;
      @(negedge clk);
      if ({word_valid, word_last, word_nbytes} !== {1'b1, 1'b0, 3'd4}) begin
         bad++; $display("FAIL full_ctrl: got v=%b l=%b nb=%0d want v=1 l=0 nb=4", word_valid, word_last, word_nbytes);
      end
      total++;
      if (word_data !== 32'h44332211) begin
         bad++; $display("FAIL full_data: got %h want 44332211", word_data);
      end
      total++;
      @(negedge clk);
      if ({word_valid, word_nbytes, frame_cnt} !== '0) begin
         bad++; $display("FAIL full_accept: got v=%b nb=%0d fc=%0d want 0 0 0", word_valid, word_nbytes, frame_cnt);
      end
      total++;
   endtask

   task automatic test_tlast();
      bit ok;
      push(8'hAA, 1'b0); push(8'hBB, 1'b1); push(8'hCC, 1'b0);
      wait_valid(10, ok);
      if (!ok || word_data !== 32'h0000BBAA || word_nbytes !== 3'd2 || word_last !== 1'b1 || frame_cnt !== 16'd0) begin
         bad++; $display("FAIL tlast_word: got ok=%b data=%h nb=%0d l=%b fc=%0d want 1 0000bbaa 2 1 0", ok, word_data, word_nbytes, word_last, frame_cnt);
      end
      total++;
      @(negedge clk);
      if (frame_cnt !== 16'd1 || word_valid !== 1'b0 || fifo_r_en !== 1'b1) begin
         bad++; $display("FAIL tlast_accept: got fc=%0d v=%b rd=%b want 1 0 1", frame_cnt, word_valid, fifo_r_en);
      end
      total++;
      repeat (4) @(negedge clk);
      if (word_data !== 32'h000000CC || word_nbytes !== 3'd1 || word_valid !== 1'b0) begin
         bad++; $display("FAIL tlast_next: got data=%h nb=%0d v=%b want 000000cc 1 0", word_data, word_nbytes, word_valid);
      end
      total++;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      if (word_valid !== 1'b1 || word_data !== 32'h000000CC || word_last !== 1'b0) begin
         bad++; $display("FAIL tlast_flush: got v=%b data=%h l=%b want 1 000000cc 0", word_valid, word_data, word_last);
      end
      total++;
      @(negedge clk);
   endtask

   task automatic test_flush();
      int seen = 0;
      push(8'h5A, 1'b0);
      repeat (10) begin
         @(negedge clk);
         if (word_valid !== 1'b0) seen++;
      end
      if (seen !== 0 || word_nbytes !== 3'd1 || word_data !== 32'h0000005A) begin
         bad++; $display("FAIL flush_hold: got seen=%0d nb=%0d data=%h want 0 1 0000005a", seen, word_nbytes, word_data);
      end
      total++;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      if ({word_valid, word_last, word_nbytes} !== {1'b1, 1'b0, 3'd1} || word_data !== 32'h0000005A) begin
         bad++; $display("FAIL flush_word: got v=%b l=%b nb=%0d data=%h want 1 0 1 0000005a", word_valid, word_last, word_nbytes, word_data);
      end
      total++;
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      if (word_valid !== 1'b0 || word_nbytes !== 3'd0) begin
         bad++; $display("FAIL flush_empty: got v=%b nb=%0d want 0 0", word_valid, word_nbytes);
      end
      total++;
   endtask

   task automatic test_backpressure();
      bit ok;
      int base;
      int unstable = 0;
      word_ready = 1'b0;
      base = rd_ptr;
      for (int i = 1; i <= 6; i++) push(8'h60 + 8'(i), 1'b0);
      wait_valid(20, ok);
      if (!ok || word_data !== 32'h64636261 || word_nbytes !== 3'd4) begin
         bad++; $display("FAIL bp_word: got ok=%b data=%h nb=%0d want 1 64636261 4", ok, word_data, word_nbytes);
      end
      total++;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #1;
         if (word_data !== 32'h64636261 || word_nbytes !== 3'd4 || word_valid !== 1'b1 || fifo_r_en !== 1'b0) unstable++;
      end
      if (unstable !== 0 || rd_ptr - base !== 4) begin
         bad++; $display("FAIL bp_stall: got unstable=%0d reads=%0d want 0 4", unstable, rd_ptr - base);
      end
      total++;
      word_ready = 1'b1;
      @(negedge clk); #1;
      if (word_valid !== 1'b0 || fifo_r_en !== 1'b1) begin
         bad++; $display("FAIL bp_resume: got v=%b rd=%b want 0 1", word_valid, fifo_r_en);
      end
      total++;
      repeat (4) @(negedge clk);
      if (word_data !== 32'h00006665 || word_nbytes !== 3'd2 || rd_ptr - base !== 6) begin
         bad++; $display("FAIL bp_rest: got data=%h nb=%0d reads=%0d want 00006665 2 6", word_data, word_nbytes, rd_ptr - base);
      end
      total++;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_gaps();
      int errs = 0;
      word_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         push(8'h71 + 8'(i), (i == 2));
         repeat (3) @(negedge clk);
         if (i < 2 && (word_nbytes !== 3'(i + 1) || word_valid !== 1'b0 || fifo_r_en !== 1'b0)) errs++;
      end
      if (errs !== 0) begin
         bad++; $display("FAIL gap_partial: got errs=%0d want 0", errs);
      end
      total++;
      if (word_valid !== 1'b1 || word_data !== 32'h00737271 || word_nbytes !== 3'd3 || word_last !== 1'b1) begin
         bad++; $display("FAIL gap_word: got v=%b data=%h nb=%0d l=%b want 1 00737271 3 1", word_valid, word_data, word_nbytes, word_last);
      end
      total++;
      word_ready = 1'b1;
      @(negedge clk);
      if (frame_cnt !== 16'd2 || word_valid !== 1'b0) begin
         bad++; $display("FAIL gap_frame: got fc=%0d v=%b want 2 0", frame_cnt, word_valid);
      end
      total++;
   endtask

   task automatic test_en();
      bit ok;
      int base;
      @(negedge clk);
      base = rd_ptr;
      push(8'h91, 1'b0); push(8'h92, 1'b0); push(8'h93, 1'b1);
      @(negedge clk);
      en = 1'b0;
      #1;
      if (fifo_r_en !== 1'b0) begin
         bad++; $display("FAIL en_gate: got rd=%b want 0", fifo_r_en);
      end
      total++;
      repeat (4) @(negedge clk);
      if (word_nbytes !== 3'd1 || word_valid !== 1'b0 || rd_ptr - base !== 1) begin
         bad++; $display("FAIL en_hold: got nb=%0d v=%b reads=%0d want 1 0 1", word_nbytes, word_valid, rd_ptr - base);
      end
      total++;
      en = 1'b1;
      wait_valid(10, ok);
      if (!ok || word_data !== 32'h00939291 || word_nbytes !== 3'd3 || word_last !== 1'b1) begin
         bad++; $display("FAIL en_word: got ok=%b data=%h nb=%0d l=%b want 1 00939291 3 1", ok, word_data, word_nbytes, word_last);
      end
      total++;
      @(negedge clk);
      if (frame_cnt !== 16'd3) begin
         bad++; $display("FAIL en_frame: got fc=%0d want 3", frame_cnt);
      end
      total++;
   endtask

   task automatic test_clr();
      bit ok;
      push(8'h81, 1'b0); push(8'h82, 1'b0); push(8'h83, 1'b0);
      repeat (3) @(negedge clk);
      if (word_nbytes !== 3'd2) begin
         bad++; $display("FAIL clr_pre: got nb=%0d want 2", word_nbytes);
      end
      total++;
      push(8'h01, 1'b0);
      clr = 1'b1;
      #1;
      if (fifo_r_en !== 1'b0) begin
         bad++; $display("FAIL clr_rd: got rd=%b want 0", fifo_r_en);
      end
      total++;
      @(negedge clk);
      clr = 1'b0;
      if ({word_valid, word_nbytes, frame_cnt, word_data} !== '0) begin
         bad++; $display("FAIL clr_state: got v=%b nb=%0d fc=%0d data=%h want all 0", word_valid, word_nbytes, frame_cnt, word_data);
      end
      total++;
      push(8'h02, 1'b0); push(8'h03, 1'b0); push(8'h04, 1'b0);
      wait_valid(20, ok);
      if (!ok || word_data !== 32'h04030201 || word_nbytes !== 3'd4 || word_last !== 1'b0) begin
         bad++; $display("FAIL clr_after: got ok=%b data=%h nb=%0d l=%b want 1 04030201 4 0", ok, word_data, word_nbytes, word_last);
      end
      total++;
      @(negedge clk);
   endtask

   task automatic test_arst();
      bit ok;
      push(8'hA1, 1'b0); push(8'hA2, 1'b1);
      wait_valid(20, ok);
      @(negedge clk);
      word_ready = 1'b0;
      push(8'hB1, 1'b0); push(8'hB2, 1'b0); push(8'hB3, 1'b0); push(8'hB4, 1'b0);
      wait_valid(20, ok);
      if (!ok || frame_cnt !== 16'd1 || word_data !== 32'hB4B3B2B1) begin
         bad++; $display("FAIL arst_pre: got ok=%b fc=%0d data=%h want 1 1 b4b3b2b1", ok, frame_cnt, word_data);
      end
      total++;
      #2;
      arst = 1'b1;
      #1;
      if ({fifo_r_en, word_valid, word_last, word_data, word_nbytes, frame_cnt} !== '0) begin
         bad++; $display("FAIL arst_async: got rd=%b v=%b l=%b data=%h nb=%0d fc=%0d want all 0", fifo_r_en, word_valid, word_last, word_data, word_nbytes, frame_cnt);
      end
      total++;
      @(negedge clk);
      arst = 1'b0;
   endtask

   initial begin
      arst = 1'b1;
      en = 1'b0;
      clr = 1'b0;
      flush = 1'b0;
      word_ready = 1'b0;
      test_reset();
      test_full_word();
      test_tlast();
      test_flush();
      test_backpressure();
      test_gaps();
      test_en();
      test_clr();
      test_arst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
